// File: rtl/iccm_dumper.sv
// ICCM readback: streams word_count words from address 0 MSB-first to a UART TX, then the loader's end marker.
// Two cycles per word before the first byte; each byte waits for tx_active_i low and then for tx_done_i.
module iccm_dumper #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] TERM_WORD = 32'h00000fff,
  parameter bit          SEND_TERM = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] word_count_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [31:0]       rdata_i,
  output logic              tx_dv_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_active_i,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {IDLE, RD, CAP, SEND, WTX, TERM, FIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d, word_sh;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic              term_q, term_d;
  logic              req_q, req_d, dv_q, dv_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]        byte_q, byte_d;

  // Current byte is always the top byte after shifting out the ones already sent.
  assign word_sh = word_q << {idx_q, 3'b000};

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    term_d  = term_q;
    req_d   = 1'b0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d  = word_count_i;
          addr_d = '0;
          term_d = 1'b0;
          if (word_count_i == '0) begin
            state_d = SEND_TERM ? TERM : FIN;
          end else begin
            state_d = RD;
            req_d   = 1'b1;
          end
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        word_d  = rdata_i;
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_active_i) begin
          dv_d    = 1'b1;
          byte_d  = word_sh[31:24];
          state_d = WTX;
        end
      end
      WTX: begin
        if (tx_done_i) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = SEND;
          end else if (term_q) begin
            state_d = FIN;
          end else if (cnt_q > ADDR_W'(1)) begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - ADDR_W'(1);
            state_d = RD;
            req_d   = 1'b1;
          end else begin
            state_d = SEND_TERM ? TERM : FIN;
          end
        end
      end
      TERM: begin
        word_d  = TERM_WORD;
        idx_d   = 2'd0;
        term_d  = 1'b1;
        state_d = SEND;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      term_q  <= 1'b0;
      req_q   <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      term_q  <= term_d;
      req_q   <= req_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_o     = req_q;
  assign addr_o    = addr_q;
  assign tx_dv_o   = dv_q;
  assign tx_byte_o = byte_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_iccm_dumper.sv
// Directed bench for iccm_dumper with an ICCM model, a UART TX frame model and a loader-side word reassembler.
`timescale 1ns/1ps
module tb_iccm_dumper;
  localparam int AW    = 14;
  localparam int FRAME = 10;

  logic          clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni, start_i, req_o, tx_dv_o, tx_active_i, tx_done_i, busy_o, done_o;
  logic [AW-1:0] word_count_i, addr_o;
  logic [31:0]   rdata_i;
  logic [7:0]    tx_byte_o;

  logic          start_b, req_b, dv_b, busy_b, done_b, act_b, txd_b;
  logic [AW-1:0] wc_b, addr_b;
  logic [31:0]   rdata_b;
  logic [7:0]    byte_b;

  logic model_active, model_done, hold_active, spur_done;
  assign tx_active_i = model_active | hold_active;
  assign tx_done_i   = model_done | spur_done;

  iccm_dumper #(.ADDR_W(AW), .TERM_WORD(32'h00000fff), .SEND_TERM(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .word_count_i(word_count_i),
    .req_o(req_o), .addr_o(addr_o), .rdata_i(rdata_i), .tx_dv_o(tx_dv_o),
    .tx_byte_o(tx_byte_o), .tx_active_i(tx_active_i), .tx_done_i(tx_done_i),
    .busy_o(busy_o), .done_o(done_o));

  iccm_dumper #(.ADDR_W(AW), .TERM_WORD(32'h00000fff), .SEND_TERM(1'b0)) dut_nt (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b), .word_count_i(wc_b),
    .req_o(req_b), .addr_o(addr_b), .rdata_i(rdata_b), .tx_dv_o(dv_b),
    .tx_byte_o(byte_b), .tx_active_i(act_b), .tx_done_i(txd_b),
    .busy_o(busy_b), .done_o(done_b));

  int          checks, errors;
  logic [31:0] mem [0:63];
  logic [7:0]  bytes_q [$];
  logic [AW-1:0] req_log [$];
  int          done_cnt, dv_viol, stab_viol, cyc, last_done_cyc, last_txdone_cyc, fcnt;
  logic        req_prev, act_seen;
  logic [AW-1:0] addr_prev;
  logic [7:0]  cur_byte;

  // ICCM answers one cycle after req_o; TX model runs FRAME-cycle frames then pulses done.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (!rst_ni) begin
      model_active = 1'b0;
      model_done   = 1'b0;
      fcnt         = 0;
      req_prev     = 1'b0;
      rdata_i      = 32'h5A5A5A5A;
    end else begin
      act_seen = tx_active_i;
      rdata_i  = req_prev ? mem[addr_prev[5:0]] : 32'h5A5A5A5A;
      req_prev  = req_o;
      addr_prev = addr_o;
      if (req_o) req_log.push_back(addr_o);
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      model_done = 1'b0;
      if (model_active) begin
        if (tx_byte_o !== cur_byte) stab_viol++;
        fcnt--;
        if (fcnt == 0) begin
          model_active    = 1'b0;
          model_done      = 1'b1;
          last_txdone_cyc = cyc;
        end
      end
      if (tx_dv_o) begin
        if (act_seen) dv_viol++;
        bytes_q.push_back(tx_byte_o);
        cur_byte     = tx_byte_o;
        model_active = 1'b1;
        fcnt         = FRAME;
      end
    end
  end

  task automatic clear_logs();
    bytes_q.delete();
    req_log.delete();
    done_cnt  = 0;
    dv_viol   = 0;
    stab_viol = 0;
  endtask

  task automatic start_dump(input logic [AW-1:0] n);
    @(negedge clk_i);
    word_count_i = n;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req_o); end
    checks++; if (addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr_o); end
    checks++; if (tx_dv_o !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", tx_dv_o); end
    checks++; if (tx_byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", tx_byte_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_main();
    logic [7:0] exp [12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h0F, 8'hFF};
    bit ok;
    clear_logs();
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h00000013;
    start_dump(AW'(2));
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL main_timeout got no done exp done"); end
    repeat (5) @(negedge clk_i);
    checks++; if (bytes_q.size() != 12) begin errors++; $display("FAIL main_nbytes got %0d exp 12", bytes_q.size()); end
    for (int i = 0; i < 12 && i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[i] !== exp[i]) begin errors++; $display("FAIL main_byte%0d got %h exp %h", i, bytes_q[i], exp[i]); end
    end
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL main_nreq got %0d exp 2", req_log.size()); end
    else begin
      checks++; if (req_log[0] !== AW'(0) || req_log[1] !== AW'(1)) begin errors++; $display("FAIL main_addr got %0d,%0d exp 0,1", req_log[0], req_log[1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL main_ndone got %0d exp 1", done_cnt); end
    checks++; if (last_done_cyc != last_txdone_cyc + 2) begin errors++; $display("FAIL main_done_lat got %0d exp 2", last_done_cyc - last_txdone_cyc); end
    checks++; if (dv_viol != 0 || stab_viol != 0) begin errors++; $display("FAIL main_tx_proto got dv=%0d stab=%0d exp 0,0", dv_viol, stab_viol); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL main_busy_end got %b exp 0", busy_o); end
  endtask

  task automatic test_zero_term();
    logic [7:0] exp [4] = '{8'h00, 8'h00, 8'h0F, 8'hFF};
    bit ok;
    clear_logs();
    start_dump(AW'(0));
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got no done exp done"); end
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL zero_nreq got %0d exp 0", req_log.size()); end
    checks++; if (bytes_q.size() != 4) begin errors++; $display("FAIL zero_nbytes got %0d exp 4", bytes_q.size()); end
    for (int i = 0; i < 4 && i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[i] !== exp[i]) begin errors++; $display("FAIL zero_byte%0d got %h exp %h", i, bytes_q[i], exp[i]); end
    end
  endtask

  task automatic test_zero_noterm();
    logic any_dv = 1'b0, any_req = 1'b0;
    @(negedge clk_i);
    wc_b    = '0;
    start_b = 1'b1;
    @(negedge clk_i);
    start_b = 1'b0;
    any_dv  = dv_b;
    any_req = req_b;
    checks++; if (busy_b !== 1'b1 || done_b !== 1'b0) begin errors++; $display("FAIL nt_cycle1 got busy=%b done=%b exp 1,0", busy_b, done_b); end
    @(negedge clk_i);
    any_dv  = any_dv | dv_b;
    any_req = any_req | req_b;
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL nt_done got %b exp 1", done_b); end
    @(negedge clk_i);
    any_dv = any_dv | dv_b;
    checks++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL nt_after got done=%b busy=%b exp 0,0", done_b, busy_b); end
    checks++; if (any_dv !== 1'b0 || any_req !== 1'b0) begin errors++; $display("FAIL nt_quiet got dv=%b req=%b exp 0,0", any_dv, any_req); end
  endtask

  task automatic test_hold_active();
    logic [7:0] exp [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h0F, 8'hFF};
    bit ok;
    clear_logs();
    mem[0] = 32'hDEADBEEF;
    hold_active = 1'b1;
    start_dump(AW'(1));
    repeat (50) @(negedge clk_i);
    checks++; if (bytes_q.size() != 0) begin errors++; $display("FAIL hold_no_dv got %0d exp 0", bytes_q.size()); end
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL hold_nreq got %0d exp 1", req_log.size()); end
    hold_active = 1'b0;
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got no done exp done"); end
    checks++; if (bytes_q.size() != 8) begin errors++; $display("FAIL hold_nbytes got %0d exp 8", bytes_q.size()); end
    for (int i = 0; i < 8 && i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[i] !== exp[i]) begin errors++; $display("FAIL hold_byte%0d got %h exp %h", i, bytes_q[i], exp[i]); end
    end
    checks++; if (dv_viol != 0 || stab_viol != 0) begin errors++; $display("FAIL hold_tx_proto got dv=%0d stab=%0d exp 0,0", dv_viol, stab_viol); end
  endtask

  task automatic test_restart_spurious();
    logic [7:0] exp [12] = '{8'h00, 8'h00, 8'h0F, 8'hFF, 8'hA5, 8'hC3, 8'h3C, 8'h5A, 8'h00, 8'h00, 8'h0F, 8'hFF};
    bit ok;
    bit seen;
    clear_logs();
    mem[0] = 32'h00000FFF;
    mem[1] = 32'hA5C33C5A;
    start_dump(AW'(2));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rs_req_wait got no req exp req"); end
    @(posedge clk_i);
    #2 spur_done = 1'b1;
    @(posedge clk_i);
    #2 spur_done = 1'b0;
    for (int i = 0; i < 200 && bytes_q.size() < 3; i++) @(negedge clk_i);
    start_dump(AW'(5));
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_timeout got no done exp done"); end
    repeat (20) @(negedge clk_i);
    checks++; if (bytes_q.size() != 12) begin errors++; $display("FAIL rs_nbytes got %0d exp 12", bytes_q.size()); end
    for (int i = 0; i < 12 && i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[i] !== exp[i]) begin errors++; $display("FAIL rs_byte%0d got %h exp %h", i, bytes_q[i], exp[i]); end
    end
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL rs_nreq got %0d exp 2", req_log.size()); end
    checks++; if (done_cnt != 1 || busy_o !== 1'b0) begin errors++; $display("FAIL rs_single_done got done=%0d busy=%b exp 1,0", done_cnt, busy_o); end
  endtask

  task automatic test_reset_midway();
    logic [7:0] exp [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h0F, 8'hFF};
    bit ok;
    clear_logs();
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    start_dump(AW'(2));
    for (int i = 0; i < 500 && bytes_q.size() < 7; i++) @(negedge clk_i);
    checks++; if (bytes_q.size() != 7 || tx_byte_o !== 8'h56) begin errors++; $display("FAIL rm_pre got n=%0d byte=%h exp 7,56", bytes_q.size(), tx_byte_o); end
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || tx_byte_o !== 8'h00 || addr_o !== '0) begin errors++; $display("FAIL rm_async got busy=%b byte=%h addr=%0d exp 0,00,0", busy_o, tx_byte_o, addr_o); end
    checks++; if (req_o !== 1'b0 || tx_dv_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rm_async2 got req=%b dv=%b done=%b exp 0,0,0", req_o, tx_dv_o, done_o); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    clear_logs();
    start_dump(AW'(1));
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got no done exp done"); end
    checks++; if (bytes_q.size() != 8) begin errors++; $display("FAIL rm_nbytes got %0d exp 8", bytes_q.size()); end
    for (int i = 0; i < 8 && i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[i] !== exp[i]) begin errors++; $display("FAIL rm_byte%0d got %h exp %h", i, bytes_q[i], exp[i]); end
    end
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL rm_nreq got %0d exp 1", req_log.size()); end
  endtask

  task automatic test_loopback();
    logic [31:0] lmem [0:63];
    logic [31:0] w;
    int          n = 0, bad = 0, badaddr = 0;
    bit          released = 1'b0, ok;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == 32'h00000fff) w = w ^ 32'h1;
      mem[i] = w;
      lmem[i] = '0;
    end
    clear_logs();
    start_dump(AW'(64));
    wait_done(20000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lb_timeout got no done exp done"); end
    for (int i = 0; i + 3 < bytes_q.size() && !released; i += 4) begin
      w = {bytes_q[i], bytes_q[i+1], bytes_q[i+2], bytes_q[i+3]};
      if (w == 32'h00000fff) released = 1'b1;
      else if (n < 64) begin
        lmem[n] = w;
        n++;
      end
    end
    for (int i = 0; i < 64; i++) if (lmem[i] !== mem[i]) bad++;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] !== AW'(i)) badaddr++;
    checks++; if (!released) begin errors++; $display("FAIL lb_release got 0 exp 1"); end
    checks++; if (n != 64) begin errors++; $display("FAIL lb_nwords got %0d exp 64", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL lb_data got %0d bad words exp 0", bad); end
    checks++; if (req_log.size() != 64 || badaddr != 0) begin errors++; $display("FAIL lb_addr got n=%0d bad=%0d exp 64,0", req_log.size(), badaddr); end
    checks++; if (dv_viol != 0 || stab_viol != 0) begin errors++; $display("FAIL lb_tx_proto got dv=%0d stab=%0d exp 0,0", dv_viol, stab_viol); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; dv_viol = 0; stab_viol = 0;
    last_done_cyc = 0; last_txdone_cyc = 0; fcnt = 0;
    model_active = 1'b0; model_done = 1'b0; hold_active = 1'b0; spur_done = 1'b0;
    req_prev = 1'b0; addr_prev = '0; cur_byte = '0; rdata_i = 32'h5A5A5A5A;
    rst_ni = 1'b0; start_i = 1'b0; word_count_i = '0;
    start_b = 1'b0; wc_b = '0; rdata_b = '0; act_b = 1'b0; txd_b = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_main();
    test_zero_term();
    test_zero_noterm();
    test_hold_active();
    test_restart_spurious();
    test_reset_midway();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iccm_dumper.md
Name: iccm_dumper

Overview:
Readback counterpart of the UART-driven ICCM loader. On a start pulse it reads a programmed number of 32-bit words from ICCM, starting at address 0. Each word is serialized MSB-first as four bytes to the UART transmitter, so the loader's byte order is reproduced exactly. The stream ends with the loader's end-of-program marker, so a captured dump can be replayed directly into the loader.

Parameters:
ADDR_W, 14, ICCM word-address width
TERM_WORD, 32'h00000fff, end-of-stream marker word sent after the last data word
SEND_TERM, 1, 1 = append TERM_WORD after the data, 0 = omit it

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  single-cycle start request; ignored unless state is IDLE
word_count_i  input  ADDR_W  number of words to dump; sampled when start is accepted
req_o  output  1  ICCM read strobe, one cycle per word
addr_o  output  ADDR_W  ICCM word address
rdata_i  input  32  ICCM read data, valid exactly one cycle after req_o
tx_dv_o  output  1  one-cycle byte-valid pulse to UART TX
tx_byte_o  output  8  byte to transmit; held stable from tx_dv_o until tx_done_i
tx_active_i  input  1  UART TX busy (in the middle of a frame)
tx_done_i  input  1  UART TX one-cycle pulse at the end of the stop bit
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse when the dump completes

Behaviour:
- Reset values: req_o=0, addr_o=0, tx_dv_o=0, tx_byte_o=0, busy_o=0, done_o=0; state=IDLE, word register=0, byte index=0, word counter=0.
- Reset asserted mid-operation aborts immediately with no flush. A partially sent byte is the transmitter's concern.
- All outputs are registered.
- States:
  - IDLE: on start_i, latch word_count_i into cnt_q and clear addr_q. If cnt_q would be 0, go to TERM when SEND_TERM=1, else to FIN. Otherwise go to RD.
  - RD: req_o=1 for exactly one cycle with addr_o=addr_q; go to CAP.
  - CAP: capture rdata_i into word_q; byte index=0; go to SEND.
  - SEND: wait until tx_active_i=0. Then drive tx_byte_o = word_q[31-8*idx -: 8] with tx_dv_o=1 for one cycle; go to WTX.
  - WTX: wait for tx_done_i. Then:
    - idx<3: idx++, go to SEND.
    - idx==3 and cnt_q>1: addr_q++, cnt_q--, go to RD.
    - idx==3 and cnt_q==1: go to TERM if SEND_TERM=1 (word_q<=TERM_WORD, idx=0), else to FIN.
  - TERM: the SEND/WTX byte sequence applied to TERM_WORD (00,0f... order MSB-first: 00,00,0f,ff). After the 4th tx_done_i go to FIN. A flag distinguishes the data phase from the terminator phase.
  - FIN: done_o=1 for one cycle; go to IDLE.
- tx_dv_o never asserts while tx_active_i=1 and never more than once per byte.
- tx_done_i outside WTX (or the terminator wait) is ignored.
- start_i while busy_o=1 is ignored; it is not queued.
- Address arithmetic is ADDR_W bits. The maximum count is 2^ADDR_W-1 words (addresses 0..count-1), so no wrap occurs.
- Data is never modified: words equal to TERM_WORD inside the data region are sent verbatim.
- Per-word latency: 2 cycles (RD, CAP) before the first byte can be offered.

Test Plan:
- ICCM[0]=32'hDEADBEEF, ICCM[1]=32'h00000013, start with word_count_i=2, TX model with 10-cycle frames -> bytes DE,AD,BE,EF,00,00,00,13,00,00,0f,ff in order; exactly 2 req_o pulses at addr 0 and 1; one done_o pulse after the last tx_done_i.
- word_count_i=0, SEND_TERM=1 -> no req_o; bytes 00,00,0f,ff; done_o. Repeat with SEND_TERM=0 -> no bytes, done_o 2 cycles after start_i.
- tx_active_i held high 50 cycles when SEND is entered -> tx_dv_o stays 0 until tx_active_i falls, then pulses once; tx_byte_o is stable until tx_done_i.
- start_i re-pulsed mid-dump, plus a spurious tx_done_i in CAP -> byte sequence and count unchanged; a single done_o.
- rst_ni dropped during the 3rd byte of word 1 -> all outputs return to reset values asynchronously; a new start with count 1 dumps word 0 correctly.
- Loopback: dumper output fed through the UART model into the loader with a 64-word random image -> loader's ICCM contents match the source and the loader raises its reset-release output.
